// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// control_pkg : writeback-select, load-format and writeback-state encodings
// Revision    : 1.0
// ============================================================================
package control_pkg;

  typedef enum logic [1:0] {
    WB_FROM_ALU       = 2'b00,
    WB_FROM_MEM       = 2'b01,
    WB_FROM_PC_PLUS_4 = 2'b10
  } wb_sel_e;

  // Encodings match the RISC-V load funct3 field
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_fmt_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_LOAD = 2'b01,
    DRAIN     = 2'b10
  } wb_state_e;

  function automatic logic is_load_sel(input logic [1:0] sel);
    return sel == WB_FROM_MEM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// load_extend : selects the addressed lane of a raw memory word and extends it
// Revision    : 1.0
// ============================================================================
module load_extend
  import control_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      fmt,
  input  logic [AW-1:0]   addr_lo,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [AW-1:0]   lane;
  logic [XLEN-1:0] shifted;

  // Misaligned offsets are rounded down to the access size
  always_comb begin
    lane = addr_lo;
    case (fmt)
      LH, LHU: lane = addr_lo & ~AW'(1);
      LW, LWU: lane = addr_lo & ~AW'(3);
      LD:      lane = '0;
      default: lane = addr_lo;
    endcase
  end

  assign shifted = raw >> {lane, 3'b000};

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (fmt)
      LB:  data = XLEN'($signed(shifted[7:0]));
      LH:  data = XLEN'($signed(shifted[15:0]));
      LW:  data = XLEN'($signed(shifted[31:0]));
      LBU: data = XLEN'(shifted[7:0]);
      LHU: data = XLEN'(shifted[15:0]);
      LD: begin
        if (XLEN == 64) data = shifted;
        else            illegal = 1'b1;
      end
      LWU: begin
        if (XLEN == 64) data = XLEN'(shifted[31:0]);
        else            illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// wb_stage_pipe : MEM/WB register, load wait/format, register-file write port
// Optional      : `define WB_RETIRE_CNT_EN adds the 64-bit retire_cnt output
// Revision      : 1.0
// ============================================================================
module wb_stage_pipe
  import control_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              REG_ADDR_W  = 5,
  parameter logic [XLEN-1:0] POISON_DATA = XLEN'(32'hDEADBEEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_alu_result,
  input  logic [XLEN-1:0]           in_pc_plus_4,
  input  logic [1:0]                in_wb_sel,
  input  logic [REG_ADDR_W-1:0]     in_rd,
  input  logic                      in_regwrite,
  input  logic [2:0]                in_load_fmt,
  input  logic [$clog2(XLEN/8)-1:0] in_addr_lo,
  input  logic                      flush,
  input  logic                      dmem_rvalid,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic [REG_ADDR_W-1:0]     wb_rd,
  output logic [XLEN-1:0]           wb_data,
  output logic                      wb_regwen,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]               retire_cnt,
`endif
  output logic                      wb_load_pending
);

  localparam int AW = $clog2(XLEN/8);

  wb_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_regwen_q, wb_regwen_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  ld_regwrite_q, ld_regwrite_d;
  logic [2:0]            ld_fmt_q, ld_fmt_d;
  logic [AW-1:0]         ld_addr_lo_q, ld_addr_lo_d;

  logic            accept;
  logic [XLEN-1:0] ld_data;
  logic            ld_illegal;

  load_extend #(.XLEN(XLEN), .AW(AW)) u_load_extend (
    .raw     (dmem_rdata),
    .fmt     (ld_fmt_q),
    .addr_lo (ld_addr_lo_q),
    .data    (ld_data),
    .illegal (ld_illegal)
  );

  assign in_ready = (state_q == IDLE);
  // A flush in IDLE blocks acceptance so the flushed instruction never writes
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d       = state_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_regwen_d   = 1'b0;
    ld_rd_d       = ld_rd_q;
    ld_regwrite_d = ld_regwrite_q;
    ld_fmt_d      = ld_fmt_q;
    ld_addr_lo_d  = ld_addr_lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load_sel(in_wb_sel)) begin
            ld_rd_d       = in_rd;
            ld_regwrite_d = in_regwrite;
            ld_fmt_d      = in_load_fmt;
            ld_addr_lo_d  = in_addr_lo;
            state_d       = WAIT_LOAD;
          end else begin
            wb_rd_d     = in_rd;
            wb_regwen_d = in_regwrite && (in_rd != '0);
            case (in_wb_sel)
              WB_FROM_ALU:       wb_data_d = in_alu_result;
              WB_FROM_PC_PLUS_4: wb_data_d = in_pc_plus_4;
              default:           wb_data_d = POISON_DATA;
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          if (!flush) begin
            wb_rd_d     = ld_rd_q;
            wb_data_d   = ld_illegal ? POISON_DATA : ld_data;
            wb_regwen_d = ld_regwrite_q && (ld_rd_q != '0);
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      wb_regwen_q   <= 1'b0;
      ld_rd_q       <= '0;
      ld_regwrite_q <= 1'b0;
      ld_fmt_q      <= '0;
      ld_addr_lo_q  <= '0;
    end else begin
      state_q       <= state_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_regwen_q   <= wb_regwen_d;
      ld_rd_q       <= ld_rd_d;
      ld_regwrite_q <= ld_regwrite_d;
      ld_fmt_q      <= ld_fmt_d;
      ld_addr_lo_q  <= ld_addr_lo_d;
    end
  end

  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign wb_regwen       = wb_regwen_q;
  assign wb_load_pending = (state_q == WAIT_LOAD) || (state_q == DRAIN);

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;
  logic        retire;

  // Completion counts even when rd is x0 or regwrite is low
  always_comb begin
    retire = ((state_q == IDLE) && accept && !is_load_sel(in_wb_sel)) ||
             ((state_q == WAIT_LOAD) && dmem_rvalid && !flush);
    retire_cnt_d = retire_cnt_q + 64'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) retire_cnt_q <= '0;
    else     retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// Scoreboard bench for wb_stage_pipe: expected register writes are queued as
// stimulus is driven and popped whenever the DUT strobes wb_regwen.
module tb_wb_stage_pipe;
  import control_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus_4;
  logic [1:0]      in_wb_sel;
  logic [RW-1:0]   in_rd;
  logic            in_regwrite;
  logic [2:0]      in_load_fmt;
  logic [1:0]      in_addr_lo;
  logic            flush;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_regwen;
  logic            wb_load_pending;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]     retire_cnt;
`endif

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_alu_result   (in_alu_result),
    .in_pc_plus_4    (in_pc_plus_4),
    .in_wb_sel       (in_wb_sel),
    .in_rd           (in_rd),
    .in_regwrite     (in_regwrite),
    .in_load_fmt     (in_load_fmt),
    .in_addr_lo      (in_addr_lo),
    .flush           (flush),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .wb_regwen       (wb_regwen),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt      (retire_cnt),
`endif
    .wb_load_pending (wb_load_pending)
  );

  // Every observed write must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && wb_regwen) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got rd=%0d data=%h, required no write", wb_rd, wb_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    flush       = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
  endtask

  task automatic drive_instr(input logic [1:0] sel, input logic [RW-1:0] rd, input logic rw,
                             input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc4,
                             input logic [2:0] fmt, input logic [1:0] alo);
    in_valid      = 1'b1;
    in_wb_sel     = sel;
    in_rd         = rd;
    in_regwrite   = rw;
    in_alu_result = alu;
    in_pc_plus_4  = pc4;
    in_load_fmt   = fmt;
    in_addr_lo    = alo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    drive_instr(WB_FROM_ALU, 5'd0, 1'b0, '0, '0, 3'b000, 2'b00);
    in_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (wb_regwen !== 1'b0 || wb_rd !== '0 || wb_data !== '0 || wb_load_pending !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got regwen=%b rd=%0d data=%h pend=%b rdy=%b, required 0 0 0 0 1",
               wb_regwen, wb_rd, wb_data, wb_load_pending, in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    drive_instr(WB_FROM_ALU, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 3'b000, 2'b00);
    sb.push_back('{rd: 5'd5, data: 32'h1234_5678});
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (wb_regwen !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL alu_path: got regwen=%b rd=%0d data=%h, required 1 5 12345678", wb_regwen, wb_rd, wb_data);
    end
    tick();
    n_checks++;
    if (wb_regwen !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_single_strobe: got regwen=%b, required 0", wb_regwen);
    end
  endtask

  task automatic test_rd_zero();
    drive_instr(WB_FROM_PC_PLUS_4, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0104, 3'b000, 2'b00);
    tick();
    n_checks++;
    if (wb_regwen !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_suppress: got regwen=%b, required 0", wb_regwen);
    end
    drive_instr(WB_FROM_PC_PLUS_4, 5'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0104, 3'b000, 2'b00);
    sb.push_back('{rd: 5'd1, data: 32'h0000_0104});
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (wb_regwen !== 1'b1 || wb_data !== 32'h0000_0104) begin
      n_fail++;
      $display("FAIL jal_link: got regwen=%b data=%h, required 1 00000104", wb_regwen, wb_data);
    end
    tick();
  endtask

  task automatic test_load(input logic [2:0] fmt, input logic [1:0] alo,
                           input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] exp);
    drive_instr(WB_FROM_MEM, 5'd9, 1'b1, 32'h0, 32'h0, fmt, alo);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    tick();
    in_valid    = 1'b0;
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || wb_load_pending !== 1'b1 || wb_regwen !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait fmt=%0d: got rdy=%b pend=%b regwen=%b, required 0 1 0",
                 fmt, in_ready, wb_load_pending, wb_regwen);
      end
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    sb.push_back('{rd: 5'd9, data: exp});
    tick();
    dmem_rvalid = 1'b0;
    n_checks++;
    if (wb_regwen !== 1'b1 || wb_data !== exp || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_result fmt=%0d: got regwen=%b data=%h rdy=%b, required 1 %h 1",
               fmt, wb_regwen, wb_data, in_ready, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      if (i % 2 == 0) begin
        drive_instr(WB_FROM_ALU, RW'(i + 10), 1'b1, v, 32'h0, 3'b000, 2'b00);
      end else begin
        drive_instr(WB_FROM_PC_PLUS_4, RW'(i + 10), 1'b1, 32'h0, v, 3'b000, 2'b00);
      end
      sb.push_back('{rd: RW'(i + 10), data: v});
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drained: got %0d pending writes, required 0", sb.size());
    end
  endtask

  task automatic test_flush();
    // Flush in IDLE blocks the instruction
    drive_instr(WB_FROM_ALU, 5'd3, 1'b1, 32'hAAAA_AAAA, 32'h0, 3'b000, 2'b00);
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    n_checks++;
    if (wb_regwen !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: got regwen=%b rdy=%b, required 0 1", wb_regwen, in_ready);
    end
    // Flush after a load accept drains the later response
    drive_instr(WB_FROM_MEM, 5'd10, 1'b1, 32'h0, 32'h0, LW, 2'b00);
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || wb_load_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_drain: got rdy=%b pend=%b, required 0 1", in_ready, wb_load_pending);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1357_9BDF;
    tick();
    dmem_rvalid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || wb_regwen !== 1'b0 || wb_load_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_load_end: got rdy=%b regwen=%b pend=%b, required 1 0 0",
               in_ready, wb_regwen, wb_load_pending);
    end
    // Flush coincident with the response
    drive_instr(WB_FROM_MEM, 5'd11, 1'b1, 32'h0, 32'h0, LW, 2'b00);
    tick();
    in_valid    = 1'b0;
    flush       = 1'b1;
    dmem_rvalid = 1'b1;
    tick();
    flush       = 1'b0;
    dmem_rvalid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || wb_regwen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_with_rvalid: got rdy=%b regwen=%b, required 1 0", in_ready, wb_regwen);
    end
    tick();
  endtask

  task automatic test_illegal_sel();
    drive_instr(2'b11, 5'd7, 1'b1, 32'h1111_1111, 32'h2222_2222, 3'b000, 2'b00);
    sb.push_back('{rd: 5'd7, data: 32'hDEAD_BEEF});
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (wb_regwen !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL illegal_sel: got regwen=%b data=%h, required 1 deadbeef", wb_regwen, wb_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_instr(WB_FROM_ALU, RW'(20 + i), 1'b1, 32'(i * 3 + 1), 32'h0, 3'b000, 2'b00);
      sb.push_back('{rd: RW'(20 + i), data: 32'(i * 3 + 1)});
      tick();
    end
    drive_instr(WB_FROM_MEM, 5'd25, 1'b1, 32'h0, 32'h0, LW, 2'b00);
    tick();
    in_valid = 1'b0;
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retire_cnt !== 64'd3) begin
      n_fail++;
      $display("FAIL retire_cnt_3: got %0d, required 3", retire_cnt);
    end
`endif
    rst = 1'b1;
    tick();
    n_checks++;
    if (wb_regwen !== 1'b0 || wb_rd !== '0 || wb_data !== '0 || wb_load_pending !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_load: got regwen=%b rd=%0d data=%h pend=%b rdy=%b, required 0 0 0 0 1",
               wb_regwen, wb_rd, wb_data, wb_load_pending, in_ready);
    end
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retire_cnt !== 64'd0) begin
      n_fail++;
      $display("FAIL retire_cnt_reset: got %0d, required 0", retire_cnt);
    end
`endif
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    n_checks++;
    if (wb_regwen !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_resp_after_reset: got regwen=%b, required 0", wb_regwen);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_rd_zero();
    test_load(LB,  2'b11, 32'h80FF_0000, 32'hFFFF_FF80);
    test_load(LBU, 2'b11, 32'h80FF_0000, 32'h0000_0080);
    test_load(LH,  2'b11, 32'h80FF_0000, 32'hFFFF_80FF);
    test_load(LHU, 2'b10, 32'h80FF_0000, 32'h0000_80FF);
    test_load(LW,  2'b01, 32'h80FF_0000, 32'h80FF_0000);
    test_load(3'b011, 2'b00, 32'h80FF_0000, 32'hDEAD_BEEF);
    test_back_to_back();
    test_flush();
    test_illegal_sel();
    test_reset_mid_load();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending writes, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
